// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU classes,
// FSM state codes and ALU operand-B selects.
package mips_defs;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB_ALU = 3'd4,
        S_WB_MEM = 3'd5,
        S_BR     = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    // Branch resolution from the latched opcode and the ALU zero flag.
    function automatic logic branch_taken(input logic [5:0] op, input logic zero);
        return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/mips_perf_cnt.sv
// Retired-instruction and cycle counters; both wrap and clear on reset.
module mips_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 retire_en,
    input  logic                 cycle_en,
    output logic [CNT_WIDTH-1:0] inst_retired,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    logic [CNT_WIDTH-1:0] inst_retired_r;
    logic [CNT_WIDTH-1:0] cycle_cnt_r;

    // Counter registers with independent increment enables.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_retired_r <= '0;
            cycle_cnt_r    <= '0;
        end else begin
            if (retire_en) begin
                inst_retired_r <= inst_retired_r + CNT_WIDTH'(1);
            end
            if (cycle_en) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign inst_retired = inst_retired_r;
    assign cycle_cnt    = cycle_cnt_r;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, driving the shared datapath and memory port.
module mips_multicycle_ctrl
    import mips_defs::*;
#(
    parameter int ALU_CODE_WIDTH = 2,
    parameter int STATE_WIDTH    = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [5:0]                opcode,
    input  logic                      alu_zero,
    output logic                      inst_req,
    input  logic                      inst_ack,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [3:0]                mem_strb,
    input  logic                      mem_ack,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic                      pc_src,
    output logic                      reg_write,
    output logic                      reg_dst,
    output logic                      mem_to_reg,
    output logic                      mdr_write,
    output logic                      alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [ALU_CODE_WIDTH-1:0] alu_code,
    output logic                      need_sign_extend,
    output logic                      illegal_op,
    output logic [STATE_WIDTH-1:0]    state_out,
    output logic [CNT_WIDTH-1:0]      inst_retired,
    output logic [CNT_WIDTH-1:0]      cycle_cnt
);

    state_t     state_r;
    state_t     next_state_s;
    logic [5:0] op_q_r;

    logic       inst_req_s, mem_req_s, mem_wr_s, ir_write_s, pc_write_s, pc_src_s;
    logic       reg_write_s, reg_dst_s, mem_to_reg_s, mdr_write_s, alu_src_a_s;
    logic       illegal_op_s;
    logic [3:0] mem_strb_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_code_s;
    logic       retire_s;

    // State and latched opcode; op_q is captured while the IR is decoded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IF;
            op_q_r  <= 6'b000000;
        end else begin
            state_r <= next_state_s;
            if (state_r == S_ID) begin
                op_q_r <= opcode;
            end
        end
    end

    // Next-state logic and control decode (Moore on state, Mealy on acks/zero).
    always_comb begin
        next_state_s = state_r;
        inst_req_s   = 1'b0;
        mem_req_s    = 1'b0;
        mem_wr_s     = 1'b0;
        mem_strb_s   = 4'b0000;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        mdr_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_RT;
        alu_code_s   = ALU_ADD;
        illegal_op_s = 1'b0;
        case (state_r)
            S_IF: begin
                inst_req_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                if (inst_ack) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_ID;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_ID: begin
                alu_src_b_s = SRCB_IMM_SH2;
                case (opcode)
                    OP_ADDIU, OP_LW, OP_SW: next_state_s = S_EX;
                    OP_BEQ, OP_BNE:         next_state_s = S_BR;
                    OP_NOP:                 next_state_s = S_IF;
                    default: begin
                        illegal_op_s = 1'b1;
                        next_state_s = S_IF;
                    end
                endcase
            end
            S_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                case (op_q_r)
                    OP_ADDIU:     next_state_s = S_WB_ALU;
                    OP_LW, OP_SW: next_state_s = S_MEM;
                    default:      next_state_s = S_IF;
                endcase
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                if (op_q_r == OP_SW) begin
                    mem_wr_s   = 1'b1;
                    mem_strb_s = 4'b1111;
                end else begin
                    mem_wr_s   = 1'b0;
                    mem_strb_s = 4'b0000;
                end
                if (!mem_ack) begin
                    next_state_s = S_MEM;
                end else if (op_q_r == OP_LW) begin
                    mdr_write_s  = 1'b1;
                    next_state_s = S_WB_MEM;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_WB_ALU: begin
                reg_write_s  = 1'b1;
                next_state_s = S_IF;
            end
            S_WB_MEM: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                next_state_s = S_IF;
            end
            S_BR: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_RT;
                alu_code_s   = ALU_SUB;
                pc_src_s     = 1'b1;
                pc_write_s   = branch_taken(op_q_r, alu_zero);
                next_state_s = S_IF;
            end
            default: begin
                next_state_s = S_IF;
            end
        endcase
    end

    assign retire_s = (state_r != S_IF) && (next_state_s == S_IF);

    mips_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk          (clk),
        .resetn       (resetn),
        .retire_en    (retire_s),
        .cycle_en     (1'b1),
        .inst_retired (inst_retired),
        .cycle_cnt    (cycle_cnt)
    );

    // Gating with resetn keeps every strobe low during reset, including IF's inst_req.
    assign inst_req         = resetn & inst_req_s;
    assign mem_req          = resetn & mem_req_s;
    assign mem_wr           = resetn & mem_wr_s;
    assign mem_strb         = {4{resetn}} & mem_strb_s;
    assign ir_write         = resetn & ir_write_s;
    assign pc_write         = resetn & pc_write_s;
    assign pc_src           = resetn & pc_src_s;
    assign reg_write        = resetn & reg_write_s;
    assign reg_dst          = resetn & reg_dst_s;
    assign mem_to_reg       = resetn & mem_to_reg_s;
    assign mdr_write        = resetn & mdr_write_s;
    assign alu_src_a        = resetn & alu_src_a_s;
    assign alu_src_b        = {2{resetn}} & alu_src_b_s;
    assign alu_code         = {ALU_CODE_WIDTH{resetn}} & alu_code_s;
    assign need_sign_extend = resetn;
    assign illegal_op       = resetn & illegal_op_s;
    assign state_out        = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle controller: each instruction class is
// stepped cycle by cycle against hand-built control vectors.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  opcode;
    logic        alu_zero, inst_ack, mem_ack;
    logic        inst_req, mem_req, mem_wr, ir_write, pc_write, pc_src;
    logic        reg_write, reg_dst, mem_to_reg, mdr_write, alu_src_a;
    logic        need_sign_extend, illegal_op;
    logic [3:0]  mem_strb;
    logic [1:0]  alu_src_b, alu_code;
    logic [2:0]  state_out;
    logic [31:0] inst_retired, cycle_cnt;

    int passed = 0;
    int total  = 0;
    logic [31:0] r0, c0;

    mips_multicycle_ctrl dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .alu_zero(alu_zero),
        .inst_req(inst_req), .inst_ack(inst_ack), .mem_req(mem_req),
        .mem_wr(mem_wr), .mem_strb(mem_strb), .mem_ack(mem_ack),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mdr_write(mdr_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_code(alu_code), .need_sign_extend(need_sign_extend),
        .illegal_op(illegal_op), .state_out(state_out),
        .inst_retired(inst_retired), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // {state, inst_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
    //  mem_to_reg, mdr_write, mem_req, mem_wr, strb, src_a, src_b, alu_code, sext, illegal}
    logic [23:0] obs;
    assign obs = {state_out, inst_req, ir_write, pc_write, pc_src, reg_write, reg_dst,
                  mem_to_reg, mdr_write, mem_req, mem_wr, mem_strb, alu_src_a,
                  alu_src_b, alu_code, need_sign_extend, illegal_op};

    localparam logic [23:0] V_RST  = 24'h000000;
    localparam logic [23:0] V_IF   = {3'd0, 10'b1000000000, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_IFA  = {3'd0, 10'b1110000000, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_ID   = {3'd1, 10'b0000000000, 4'b0000, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_IDI  = {3'd1, 10'b0000000000, 4'b0000, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1};
    localparam logic [23:0] V_EX   = {3'd2, 10'b0000000000, 4'b0000, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_MLW  = {3'd3, 10'b0000000010, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_MLWA = {3'd3, 10'b0000000110, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_MSW  = {3'd3, 10'b0000000011, 4'b1111, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_WBA  = {3'd4, 10'b0000100000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_WBM  = {3'd5, 10'b0000101000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [23:0] V_BRT  = {3'd6, 10'b0011000000, 4'b0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [23:0] V_BRN  = {3'd6, 10'b0001000000, 4'b0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; opcode = 6'b000000; alu_zero = 1'b0; inst_ack = 1'b0; mem_ack = 1'b0;
        #2;
        total++; if (obs !== V_RST) $display("FAIL reset_ctrl: got %h want %h", obs, V_RST); else passed++;
        repeat (2) @(posedge clk);
        #2;
        total++; if (cycle_cnt !== 32'd0 || inst_retired !== 32'd0) $display("FAIL reset_cnt: got cyc %0d ret %0d want 0 0", cycle_cnt, inst_retired); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total++; if (obs !== V_IF) $display("FAIL release_if: got %h want %h", obs, V_IF); else passed++;
        tick();
        total++; if (cycle_cnt !== 32'd1) $display("FAIL first_cycle: got %0d want 1", cycle_cnt); else passed++;
    endtask

    task automatic test_addiu();
        r0 = inst_retired; c0 = cycle_cnt;
        opcode = 6'b001001; inst_ack = 1'b1; #1;
        total++; if (obs !== V_IFA) $display("FAIL addiu_if: got %h want %h", obs, V_IFA); else passed++;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_ID) $display("FAIL addiu_id: got %h want %h", obs, V_ID); else passed++;
        tick(); #1;
        total++; if (obs !== V_EX) $display("FAIL addiu_ex: got %h want %h", obs, V_EX); else passed++;
        tick(); #1;
        total++; if (obs !== V_WBA) $display("FAIL addiu_wb: got %h want %h", obs, V_WBA); else passed++;
        total++; if (inst_retired !== r0) $display("FAIL addiu_ret_early: got %0d want %0d", inst_retired, r0); else passed++;
        tick(); #1;
        total++; if (obs !== V_IF) $display("FAIL addiu_back_if: got %h want %h", obs, V_IF); else passed++;
        total++; if (inst_retired !== r0 + 32'd1) $display("FAIL addiu_ret: got %0d want %0d", inst_retired, r0 + 32'd1); else passed++;
        total++; if (cycle_cnt !== c0 + 32'd4) $display("FAIL addiu_cyc: got %0d want %0d", cycle_cnt, c0 + 32'd4); else passed++;
    endtask

    task automatic test_lw_wait();
        r0 = inst_retired; c0 = cycle_cnt;
        opcode = 6'b100011; inst_ack = 1'b0; mem_ack = 1'b1; #1;
        total++; if (obs !== V_IF) $display("FAIL lw_if_wait: got %h want %h", obs, V_IF); else passed++;
        tick(); mem_ack = 1'b0; #1;
        total++; if (obs !== V_IF) $display("FAIL lw_if_stay: got %h want %h", obs, V_IF); else passed++;
        inst_ack = 1'b1; #1;
        total++; if (obs !== V_IFA) $display("FAIL lw_if_ack: got %h want %h", obs, V_IFA); else passed++;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_ID) $display("FAIL lw_id: got %h want %h", obs, V_ID); else passed++;
        tick(); #1;
        total++; if (obs !== V_EX) $display("FAIL lw_ex: got %h want %h", obs, V_EX); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick(); inst_ack = (i == 0); #1;
            total++; if (obs !== V_MLW) $display("FAIL lw_mem_hold%0d: got %h want %h", i, obs, V_MLW); else passed++;
        end
        tick(); inst_ack = 1'b0; mem_ack = 1'b1; #1;
        total++; if (obs !== V_MLWA) $display("FAIL lw_mem_ack: got %h want %h", obs, V_MLWA); else passed++;
        tick(); mem_ack = 1'b0; #1;
        total++; if (obs !== V_WBM) $display("FAIL lw_wb: got %h want %h", obs, V_WBM); else passed++;
        tick(); #1;
        total++; if (obs !== V_IF) $display("FAIL lw_back_if: got %h want %h", obs, V_IF); else passed++;
        total++; if (inst_retired !== r0 + 32'd1) $display("FAIL lw_ret: got %0d want %0d", inst_retired, r0 + 32'd1); else passed++;
        total++; if (cycle_cnt !== c0 + 32'd9) $display("FAIL lw_cyc: got %0d want %0d", cycle_cnt, c0 + 32'd9); else passed++;
    endtask

    task automatic test_sw();
        r0 = inst_retired;
        opcode = 6'b101011; inst_ack = 1'b1; #1;
        total++; if (obs !== V_IFA) $display("FAIL sw_if: got %h want %h", obs, V_IFA); else passed++;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_ID) $display("FAIL sw_id: got %h want %h", obs, V_ID); else passed++;
        tick(); mem_ack = 1'b1; #1;
        total++; if (obs !== V_EX) $display("FAIL sw_ex: got %h want %h", obs, V_EX); else passed++;
        tick(); inst_ack = 1'b1; #1;
        total++; if (obs !== V_MSW) $display("FAIL sw_mem: got %h want %h", obs, V_MSW); else passed++;
        tick(); inst_ack = 1'b0; mem_ack = 1'b0; #1;
        total++; if (obs !== V_IF) $display("FAIL sw_back_if: got %h want %h", obs, V_IF); else passed++;
        total++; if (inst_retired !== r0 + 32'd1) $display("FAIL sw_ret: got %0d want %0d", inst_retired, r0 + 32'd1); else passed++;
    endtask

    task automatic test_branch(input logic [5:0] op, input logic zero, input logic [23:0] exp_br, input string name);
        r0 = inst_retired; c0 = cycle_cnt;
        opcode = op; inst_ack = 1'b1; alu_zero = ~zero; #1;
        total++; if (obs !== V_IFA) $display("FAIL %s_if: got %h want %h", name, obs, V_IFA); else passed++;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_ID) $display("FAIL %s_id: got %h want %h", name, obs, V_ID); else passed++;
        tick(); alu_zero = zero; #1;
        total++; if (obs !== exp_br) $display("FAIL %s_br: got %h want %h", name, obs, exp_br); else passed++;
        tick(); #1;
        total++; if (obs !== V_IF || inst_retired !== r0 + 32'd1 || cycle_cnt !== c0 + 32'd3)
            $display("FAIL %s_done: got ctrl %h ret %0d cyc %0d want %h %0d %0d", name, obs, inst_retired, cycle_cnt, V_IF, r0 + 32'd1, c0 + 32'd3);
        else passed++;
    endtask

    task automatic test_illegal_and_nop();
        r0 = inst_retired;
        opcode = 6'b111111; inst_ack = 1'b1; #1;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_IDI) $display("FAIL illegal_id: got %h want %h", obs, V_IDI); else passed++;
        tick(); #1;
        total++; if (obs !== V_IF || inst_retired !== r0 + 32'd1) $display("FAIL illegal_done: got %h ret %0d want %h %0d", obs, inst_retired, V_IF, r0 + 32'd1); else passed++;
        c0 = cycle_cnt;
        opcode = 6'b000000; inst_ack = 1'b1; #1;
        tick(); inst_ack = 1'b0; #1;
        total++; if (obs !== V_ID) $display("FAIL nop_id: got %h want %h", obs, V_ID); else passed++;
        tick(); #1;
        total++; if (obs !== V_IF || inst_retired !== r0 + 32'd2 || cycle_cnt !== c0 + 32'd2)
            $display("FAIL nop_done: got %h ret %0d cyc %0d want %h %0d %0d", obs, inst_retired, cycle_cnt, V_IF, r0 + 32'd2, c0 + 32'd2);
        else passed++;
    endtask

    task automatic test_reset_mid_mem();
        opcode = 6'b100011; inst_ack = 1'b1; #1;
        tick(); inst_ack = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        total++; if (obs !== V_MLW) $display("FAIL rst_pre_mem: got %h want %h", obs, V_MLW); else passed++;
        #2; resetn = 1'b0; #1;
        total++; if (obs !== V_RST || inst_retired !== 32'd0 || cycle_cnt !== 32'd0)
            $display("FAIL rst_async: got %h ret %0d cyc %0d want %h 0 0", obs, inst_retired, cycle_cnt, V_RST);
        else passed++;
        mem_ack = 1'b1;
        tick(); tick();
        total++; if (obs !== V_RST) $display("FAIL rst_hold: got %h want %h", obs, V_RST); else passed++;
        @(negedge clk); resetn = 1'b1; mem_ack = 1'b0; #1;
        total++; if (obs !== V_IF) $display("FAIL rst_release: got %h want %h", obs, V_IF); else passed++;
        tick();
        total++; if (cycle_cnt !== 32'd1 || inst_retired !== 32'd0) $display("FAIL rst_counters: got cyc %0d ret %0d want 1 0", cycle_cnt, inst_retired); else passed++;
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_lw_wait();
        test_sw();
        test_branch(6'b000100, 1'b1, V_BRT, "beq_taken");
        test_branch(6'b000100, 1'b0, V_BRN, "beq_not");
        test_branch(6'b000101, 1'b0, V_BRT, "bne_taken");
        test_branch(6'b000101, 1'b1, V_BRN, "bne_not");
        test_illegal_and_nop();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core datapath. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and write-back.
- Drives the shared ALU, register file, PC, IR and a req/ack memory port.
- Supports addiu, lw, sw, beq, bne and nop (opcode 000000). Any other opcode raises illegal_op and is retired as a nop.
- Keeps retired-instruction and cycle counters for bench and performance use.

Parameters:
- ALU_CODE_WIDTH, 2, width of alu_code (00 add, 01 sub, 10 R-type funct).
- STATE_WIDTH, 3, width of state_out.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- alu_zero  in  1  ALU zero flag, current cycle.
- inst_req  out  1  instruction fetch request.
- inst_ack  in  1  fetch done; instruction valid on the memory bus this cycle.
- mem_req  out  1  data access request.
- mem_wr  out  1  1 = store, 0 = load; valid while mem_req=1.
- mem_strb  out  4  byte enables {b3,b2,b1,b0}.
- mem_ack  in  1  data access done; load data valid this cycle.
- ir_write  out  1  load IR from the memory bus.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- mdr_write  out  1  load MDR from the memory bus.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 rt, 01 constant 4, 10 ext(imm), 11 ext(imm)<<2.
- alu_code  out  2  ALU op class.
- need_sign_extend  out  1  1 = sign-extend imm16.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_out  out  3  current state, for debug.
- inst_retired  out  CNT_WIDTH  count of retired instructions.
- cycle_cnt  out  CNT_WIDTH  cycles since reset.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB_ALU=4, WB_MEM=5, BR=6. Code 7 is unused; if ever entered, next state is IF.
- Reset (resetn=0, asynchronous): state=IF, op_q=0, counters=0. Every output except state_out is 0 while resetn=0.
- First cycle after reset release: state is IF, so inst_req=1.
- Outputs are a Moore decode of state, except ir_write, pc_write and mdr_write, which are Mealy on inst_ack, mem_ack and alu_zero.
- Any control output not listed for a state is 0 in that state.
- need_sign_extend=1 in all states; addiu's immediate is sign-extended per MIPS32.
- IF:
  - inst_req=1, alu_src_a=0, alu_src_b=01, alu_code=00, pc_src=0.
  - While inst_ack=0: stay in IF.
  - On inst_ack=1: ir_write=1 and pc_write=1 in that same cycle, next state ID.
  - An ack in the first request cycle is legal (zero wait).
- ID:
  - alu_src_a=0, alu_src_b=11, alu_code=00 (datapath latches the branch target in ALUOut).
  - op_q <= opcode.
  - Next state by opcode:
    - addiu/lw/sw -> EX.
    - beq/bne -> BR.
    - 000000 -> IF; counts as retired.
    - any other opcode -> IF; illegal_op=1 this cycle; counts as retired.
- EX:
  - alu_src_a=1, alu_src_b=10, alu_code=00.
  - Next state: addiu -> WB_ALU; lw/sw -> MEM.
- MEM:
  - mem_req=1; mem_wr=1 for sw, 0 for lw; mem_strb=1111 for sw, 0000 for lw.
  - Request and control outputs stay stable until mem_ack.
  - On mem_ack: sw -> IF (retired); lw -> mdr_write=1, next state WB_MEM.
- WB_ALU: reg_write=1, reg_dst=0, mem_to_reg=0; next IF, retired.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1; next IF, retired.
- BR:
  - alu_src_a=1, alu_src_b=00, alu_code=01.
  - taken = (op_q==beq & alu_zero) | (op_q==bne & ~alu_zero).
  - pc_write=taken, pc_src=1; next IF, retired.
- Acks:
  - inst_ack outside IF and mem_ack outside MEM are ignored.
  - Both asserted in one cycle: only the ack for the current state is honoured.
- Counters:
  - inst_retired increments by 1 on each transition into IF from a non-IF state.
  - cycle_cnt increments every cycle after reset.
  - Both wrap modulo 2^CNT_WIDTH.
- Latency with zero-wait memory: addiu 4, lw 5, sw 4, beq/bne 3, nop 2 cycles.
- Reset asserted mid-instruction aborts it: no counter increment, and no pending write occurs after the reset edge.

Decomposition:
- Shared package mips_defs: opcode constants (OP_ADDIU 001001, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_NOP 000000), ALU code constants, state encoding, alu_src_b encoding.
- Sub-module mips_perf_cnt: the two counters with increment enables.
- FSM and output decode stay in the top module.

Test Plan:
- Zero-wait addiu (0x2401_0005): ir_write/pc_write in cycle 0; reg_write=1, mem_to_reg=0 in cycle 3; inst_retired=1 after 4 cycles.
- lw with mem_ack delayed 3 cycles: mem_req=1, mem_wr=0 held 4 cycles; mdr_write=1 on the ack cycle; then reg_write=1, mem_to_reg=1.
- sw: mem_req=1, mem_wr=1, mem_strb=1111; on ack, next state IF, reg_write never 1; inst_retired +1.
- beq and bne, each with alu_zero=1 then 0: pc_write=1 exactly when taken, with pc_src=1; 3 cycles each.
- Opcode 0x3F: illegal_op pulses 1 cycle in ID, next state IF, inst_retired +1; opcode 000000 completes in 2 cycles with no pulse.
- Reset mid-MEM (resetn=0 while mem_req=1): mem_req drops immediately (asynchronous), state_out=0, counters=0; first cycle after release has inst_req=1.
